// File: rtl/buf_arb_pkg.sv
// Shared types and helpers for the BUF sender-side arbiter.
package buf_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, REL} arb_state_e;

  localparam int DEF_NUM_SENDERS = 4;
  localparam int DEF_IDX_W       = $clog2(DEF_NUM_SENDERS);

  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
// Purely combinational; no handshake of its own.
module rr_pick
  import buf_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             vld_o,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    vld_o    = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    for (int k = 0; k < N; k++) begin
      if (!vld_o && req_i[wrap_add(int'(ptr_i), k, N)]) begin
        vld_o                                  = 1'b1;
        onehot_o[wrap_add(int'(ptr_i), k, N)] = 1'b1;
        idx_o                                  = IDX_W'(wrap_add(int'(ptr_i), k, N));
      end
    end
  end

endmodule

// File: rtl/buf_sender_arbiter.sv
// Round-robin share of the BUF sender port; 1-cycle registered hops in both directions.
// Sender-paced in HOLD; watchdog aborts REQ/REL when BUF stalls TIMEOUT cycles.
module buf_sender_arbiter
  import buf_arb_pkg::*;
#(
  parameter int NUM_SENDERS = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SENDERS-1:0]        S_REQ,
  input  logic [NUM_SENDERS*DATA_W-1:0] S_DI,
  output logic [NUM_SENDERS-1:0]        S_ACK,
  output logic                          StoB_REQ,
  output logic [DATA_W-1:0]             DI,
  input  logic                          BtoS_ACK,
  output logic [NUM_SENDERS-1:0]        grant,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int IDX_W = $clog2(NUM_SENDERS);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e             state_q;
  logic [IDX_W-1:0]       ptr_q, g_q, ptr_d;
  logic [NUM_SENDERS-1:0] grant_q, sack_q;
  logic [DATA_W-1:0]      di_q;
  logic                   stob_q, err_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   wd_hit;

  logic                   pick_vld;
  logic [NUM_SENDERS-1:0] pick_oh;
  logic [IDX_W-1:0]       pick_idx;

  rr_pick #(.N(NUM_SENDERS), .IDX_W(IDX_W)) u_pick (
    .req_i    (S_REQ),
    .ptr_i    (ptr_q),
    .vld_o    (pick_vld),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  assign cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign wd_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign ptr_d  = IDX_W'(wrap_add(int'(g_q), 1, NUM_SENDERS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      grant_q <= '0;
      sack_q  <= '0;
      di_q    <= '0;
      stob_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Holding off while BUF still acks keeps StoB_REQ from rising into a stale ACK.
          if (pick_vld && !BtoS_ACK) begin
            grant_q <= pick_oh;
            g_q     <= pick_idx;
            di_q    <= S_DI[int'(pick_idx)*DATA_W +: DATA_W];
            stob_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (BtoS_ACK) begin
            sack_q  <= grant_q;
            state_q <= HOLD;
          end else if (wd_hit) begin
            err_q   <= 1'b1;
            stob_q  <= 1'b0;
            sack_q  <= '0;
            grant_q <= '0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HOLD: begin
          if (!S_REQ[g_q]) begin
            stob_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= REL;
          end
        end
        REL: begin
          if (!BtoS_ACK) begin
            sack_q  <= '0;
            grant_q <= '0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else if (wd_hit) begin
            err_q   <= 1'b1;
            stob_q  <= 1'b0;
            sack_q  <= '0;
            grant_q <= '0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S_ACK       = sack_q;
  assign StoB_REQ    = stob_q;
  assign DI          = di_q;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;

endmodule
